// File: rtl/ahb_req_master.sv
// ahb_req_master: turns a simple request (start/write/addr/len) into an AHB-Lite
// incrementing word burst. Bursts are split at 1KB boundaries. An ERROR, RETRY or
// SPLIT response aborts the rest of the request and flags o_err.
//
// Ports
//   i_hclk, i_hreset_n             clock, async active-low reset
//   i_start, i_write, i_addr, i_len request (sampled while idle)
//   i_wdata / o_wdata_rd           write data source / consume strobe
//   o_rdata / o_rdata_vld          read beat and its qualifier
//   o_busy, o_done, o_err          request status
//   o_h*                           AHB master outputs
//   i_hready, i_hresp, i_hrdata    AHB slave responses
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no request; waiting for i_start
// ST_ADDR   | issuing address phases (previous beat's data phase overlaps)
// ST_DATA_L | all addresses issued, last data phase in flight
// ST_ERR    | error seen, waiting for the second cycle of the response
module ahb_req_master #(
  parameter int DATA_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_start,
  input  logic                i_write,
  input  logic [31:0]         i_addr,
  input  logic [4:0]          i_len,
  input  logic [DATA_WDT-1:0] i_wdata,
  output logic                o_wdata_rd,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic                o_rdata_vld,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [31:0]         o_haddr,
  output logic [1:0]          o_htrans,
  output logic [2:0]          o_hburst,
  output logic [2:0]          o_hsize,
  output logic                o_hwrite,
  output logic [DATA_WDT-1:0] o_hwdata,
  input  logic                i_hready,
  input  logic [1:0]          i_hresp,
  input  logic [DATA_WDT-1:0] i_hrdata
);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA_L, ST_ERR} state_t;

  state_t      state_q, state_d;
  logic [4:0]  beats_q;     // address phases still to issue, including the current one
  logic        dphase_q;    // a data phase is in flight
  logic [4:0]  len_eff;
  logic [2:0]  burst_sel;
  logic [31:0] haddr_nxt;
  logic        start_ok, resp_err, fault, last_beat, data_ok;

  assign o_hsize = 3'd2;

  always_comb begin
    len_eff = (i_len == 5'd0) ? 5'd1 : i_len;
    case (len_eff)
      5'd1:    burst_sel = HB_SINGLE;
      5'd4:    burst_sel = HB_INCR4;
      5'd8:    burst_sel = HB_INCR8;
      5'd16:   burst_sel = HB_INCR16;
      default: burst_sel = HB_INCR;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    haddr_nxt  = o_haddr + 32'd4;
    // o_done high means the previous request just finished; hold off one cycle
    start_ok   = (state_q == ST_IDLE) && i_start && !o_done;
    resp_err   = (i_hresp != 2'b00);
    // first cycle of a two-cycle error response
    fault      = dphase_q && !i_hready && resp_err;
    last_beat  = (beats_q == 5'd1);
    data_ok    = dphase_q && i_hready && !resp_err &&
                 ((state_q == ST_ADDR) || (state_q == ST_DATA_L));
    o_wdata_rd = (state_q == ST_ADDR) && i_hready && o_hwrite;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_ADDR;
      ST_ADDR: begin
        if (fault)                      state_d = ST_ERR;
        else if (i_hready && last_beat) state_d = ST_DATA_L;
      end
      ST_DATA_L: begin
        if (fault)         state_d = ST_ERR;
        else if (i_hready) state_d = ST_IDLE;
      end
      ST_ERR:    if (i_hready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_haddr     <= 32'd0;
      o_htrans    <= HT_IDLE;
      o_hburst    <= HB_SINGLE;
      o_hwrite    <= 1'b0;
      o_hwdata    <= '0;
      o_rdata     <= '0;
      o_rdata_vld <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      beats_q     <= 5'd0;
      dphase_q    <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_rdata_vld <= 1'b0;
      if (data_ok && !o_hwrite) begin
        o_rdata     <= i_hrdata;
        o_rdata_vld <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            o_busy   <= 1'b1;
            o_err    <= 1'b0;
            o_haddr  <= i_addr;
            o_htrans <= HT_NONSEQ;
            o_hburst <= burst_sel;
            o_hwrite <= i_write;
            beats_q  <= len_eff;
            dphase_q <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (fault) begin
            o_htrans <= HT_IDLE;
            dphase_q <= 1'b0;
          end else if (i_hready) begin
            dphase_q <= 1'b1;
            if (o_hwrite) o_hwdata <= i_wdata;
            if (last_beat) begin
              o_htrans <= HT_IDLE;
            end else begin
              o_haddr <= haddr_nxt;
              beats_q <= beats_q - 5'd1;
              // restart as an undefined-length burst on the far side of a 1KB line
              if (haddr_nxt[9:0] == 10'd0) begin
                o_htrans <= HT_NONSEQ;
                o_hburst <= HB_INCR;
              end else begin
                o_htrans <= HT_SEQ;
              end
            end
          end
        end
        ST_DATA_L: begin
          if (fault) begin
            dphase_q <= 1'b0;
          end else if (i_hready) begin
            dphase_q <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_err    <= resp_err;
          end
        end
        ST_ERR: begin
          if (i_hready) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_req_master.sv
// Directed bench for ahb_req_master with a small AHB slave model that can insert
// wait states and a two-cycle ERROR response on a chosen data phase.
module tb_ahb_req_master;

  logic        i_hclk = 1'b0;
  logic        i_hreset_n;
  logic        i_start, i_write;
  logic [31:0] i_addr;
  logic [4:0]  i_len;
  logic [31:0] i_wdata;
  logic        o_wdata_rd;
  logic [31:0] o_rdata;
  logic        o_rdata_vld, o_busy, o_done, o_err;
  logic [31:0] o_haddr;
  logic [1:0]  o_htrans;
  logic [2:0]  o_hburst, o_hsize;
  logic        o_hwrite;
  logic [31:0] o_hwdata;
  logic        i_hready;
  logic [1:0]  i_hresp;
  logic [31:0] i_hrdata;

  ahb_req_master #(.DATA_WDT(32)) dut (
    .i_hclk(i_hclk), .i_hreset_n(i_hreset_n),
    .i_start(i_start), .i_write(i_write), .i_addr(i_addr), .i_len(i_len),
    .i_wdata(i_wdata), .o_wdata_rd(o_wdata_rd),
    .o_rdata(o_rdata), .o_rdata_vld(o_rdata_vld),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hburst(o_hburst), .o_hsize(o_hsize),
    .o_hwrite(o_hwrite), .o_hwdata(o_hwdata),
    .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata)
  );

  always #5 i_hclk = ~i_hclk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // slave model / monitor state
  int          cyc = 0;
  int          start_cyc, first_ns, done_cyc, done_cnt, wrd_cnt, dp_idx, err_beat, err_ph;
  logic        done_err, dp_valid, dp_write, rnd_rdy;
  logic [31:0] dp_addr, dp_wexp;
  logic [31:0] rdy_pat = 32'hB5E6_D3A7;
  logic        prev_rdy, prev_wrd, prev_hwrite;
  logic [1:0]  prev_trans, prev_resp;
  logic [31:0] prev_addr, prev_wdata;
  logic [5:0]  prev_ctl;
  logic [31:0] aq_addr[$];
  logic [1:0]  aq_trans[$];
  logic [2:0]  aq_burst[$];
  logic [31:0] rq[$];

  task automatic slave_clr();
    first_ns = -1; done_cyc = 0; done_cnt = 0; wrd_cnt = 0; dp_idx = 0;
    err_beat = 0; err_ph = 0; done_err = 1'b0; dp_valid = 1'b0; dp_write = 1'b0;
    rnd_rdy = 1'b0; dp_addr = 32'd0; dp_wexp = 32'd0;
    prev_rdy = 1'b0; prev_wrd = 1'b0; prev_hwrite = 1'b0; prev_trans = 2'd0;
    prev_resp = 2'd0; prev_addr = 32'd0; prev_wdata = 32'd0; prev_ctl = 6'd0;
    aq_addr.delete(); aq_trans.delete(); aq_burst.delete(); rq.delete();
  endtask

  // One bus cycle: drive slave inputs after the falling edge, then sample outputs.
  task automatic tick();
    @(negedge i_hclk);
    cyc++;
    if (prev_rdy) begin
      dp_valid = (prev_trans != 2'd0);
      dp_addr  = prev_addr;
      dp_write = prev_hwrite;
      if (prev_wrd) dp_wexp = prev_wdata;
      if (dp_valid) dp_idx++;
    end
    if (dp_valid && dp_idx == err_beat && err_ph == 0) begin
      i_hready = 1'b0; i_hresp = 2'd1; err_ph = 1;
    end else if (err_ph == 1) begin
      i_hready = 1'b1; i_hresp = 2'd1; err_ph = 2;
    end else begin
      i_hready = (rnd_rdy && dp_valid) ? rdy_pat[cyc % 32] : 1'b1;
      i_hresp  = 2'd0;
    end
    i_hrdata = 32'hD000_0000 | dp_addr;
    i_wdata  = 32'hA500_0000 + wrd_cnt;
    #1;
    if (prev_trans != 2'd0 && !prev_rdy && prev_resp == 2'd0) begin
      chk("hold_addr", o_haddr, prev_addr);
      chk("hold_ctl", {o_htrans, o_hburst, o_hwrite}, prev_ctl);
    end
    if (!prev_rdy && prev_resp != 2'd0) chk("err_idle", o_htrans, 2'd0);
    if (prev_rdy && prev_resp != 2'd0)  chk("vld_on_err", o_rdata_vld, 1'b0);
    if (dp_valid && dp_write)           chk("hwdata_hold", o_hwdata, dp_wexp);
    if (o_htrans == 2'd2 && first_ns < 0) first_ns = cyc;
    if (o_htrans != 2'd0 && i_hready) begin
      aq_addr.push_back(o_haddr); aq_trans.push_back(o_htrans); aq_burst.push_back(o_hburst);
    end
    if (o_rdata_vld) rq.push_back(o_rdata);
    if (o_done) begin done_cnt++; done_cyc = cyc; done_err = o_err; end
    prev_wdata  = i_wdata;
    if (o_wdata_rd) wrd_cnt++;
    prev_rdy    = i_hready;
    prev_wrd    = o_wdata_rd;
    prev_hwrite = o_hwrite;
    prev_trans  = o_htrans;
    prev_resp   = i_hresp;
    prev_addr   = o_haddr;
    prev_ctl    = {o_htrans, o_hburst, o_hwrite};
  endtask

  task automatic start_req(input logic wr, input logic [31:0] a, input logic [4:0] l);
    i_write = wr; i_addr = a; i_len = l; i_start = 1'b1; start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    chk(tag, done_cnt != 0, 1'b1);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [31:0] a,
                          input logic [1:0] t, input logic [2:0] b);
    if (i < aq_addr.size()) begin
      chk({tag, "_addr"}, aq_addr[i], a);
      chk({tag, "_trans"}, aq_trans[i], t);
      chk({tag, "_burst"}, aq_burst[i], b);
    end else begin
      chk({tag, "_present"}, 1'b0, 1'b1);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, o_htrans, 2'd0);
    chk({tag, "_haddr"}, o_haddr, 32'd0);
    chk({tag, "_hburst"}, o_hburst, 3'd0);
    chk({tag, "_hwrite"}, o_hwrite, 1'b0);
    chk({tag, "_hsize"}, o_hsize, 3'd2);
    chk({tag, "_hwdata"}, o_hwdata, 32'd0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_wdata_rd"}, o_wdata_rd, 1'b0);
    chk({tag, "_rdata_vld"}, o_rdata_vld, 1'b0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
  endtask

  initial begin
    i_hreset_n = 1'b0; i_start = 1'b0; i_write = 1'b0; i_addr = 32'd0; i_len = 5'd0;
    i_wdata = 32'd0; i_hready = 1'b1; i_hresp = 2'd0; i_hrdata = 32'd0;
    slave_clr();
    @(negedge i_hclk); @(negedge i_hclk); #1;
    chk_reset("rst");
    i_hreset_n = 1'b1;

    // write 0x100 len 4, no wait states
    slave_clr(); tick();
    start_req(1'b1, 32'h100, 5'd4); tick(); i_start = 1'b0;
    chk("t1_busy", o_busy, 1'b1);
    wait_done("t1_done_seen", 40);
    chk("t1_ns_lat", first_ns - start_cyc, 1);
    chk("t1_done_lat", done_cyc - first_ns, 5);
    chk("t1_nbeats", aq_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_beat("t1", i, 32'h100 + 4 * i, (i == 0) ? 2'd2 : 2'd3, 3'd3);
    chk("t1_wrd", wrd_cnt, 4);
    chk("t1_err", done_err, 1'b0);
    tick(); tick(); tick();
    chk("t1_one_done", done_cnt, 1);
    chk("t1_idle_busy", o_busy, 1'b0);

    // read 0x200 len 8 with wait states
    slave_clr(); rnd_rdy = 1'b1; tick();
    start_req(1'b0, 32'h200, 5'd8); tick(); i_start = 1'b0;
    wait_done("t2_done_seen", 100);
    chk("t2_nbeats", aq_addr.size(), 8);
    chk("t2_nrd", rq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_beat("t2", i, 32'h200 + 4 * i, (i == 0) ? 2'd2 : 2'd3, 3'd5);
      if (i < rq.size()) chk("t2_rdata", rq[i], 32'hD000_0200 + 4 * i);
    end
    chk("t2_err", done_err, 1'b0);
    chk("t2_wrd", wrd_cnt, 0);

    // read across the 1KB line
    slave_clr(); tick();
    start_req(1'b0, 32'h3F8, 5'd4); tick(); i_start = 1'b0;
    wait_done("t3_done_seen", 40);
    chk("t3_nbeats", aq_addr.size(), 4);
    chk_beat("t3_b0", 0, 32'h3F8, 2'd2, 3'd3);
    chk_beat("t3_b1", 1, 32'h3FC, 2'd3, 3'd3);
    chk_beat("t3_b2", 2, 32'h400, 2'd2, 3'd1);
    chk_beat("t3_b3", 3, 32'h404, 2'd3, 3'd1);
    chk("t3_nrd", rq.size(), 4);
    if (rq.size() > 2) chk("t3_rdata2", rq[2], 32'hD000_0400);

    // write len 8 with ERROR on the third data phase
    slave_clr(); err_beat = 3; tick();
    start_req(1'b1, 32'h40, 5'd8); tick(); i_start = 1'b0;
    wait_done("t4_done_seen", 40);
    chk("t4_err", done_err, 1'b1);
    chk("t4_wrd", wrd_cnt, 3);
    chk("t4_nbeats", aq_addr.size(), 3);
    chk("t4_nrd", rq.size(), 0);
    tick(); tick(); tick(); tick();
    chk("t4_no_more_beats", aq_addr.size(), 3);
    chk("t4_no_more_wrd", wrd_cnt, 3);
    chk("t4_one_done", done_cnt, 1);
    chk("t4_busy", o_busy, 1'b0);

    // async reset during a 16-beat burst
    slave_clr(); tick();
    start_req(1'b0, 32'h800, 5'd16); tick(); i_start = 1'b0;
    for (int n = 0; n < 20 && aq_addr.size() < 2; n++) tick();
    chk("t5_reached_b2", aq_addr.size() >= 2, 1'b1);
    chk("t5_burst16", aq_burst.size() > 0 ? aq_burst[0] : 3'd0, 3'd7);
    #2 i_hreset_n = 1'b0;
    #1 chk_reset("t5_rst");
    @(negedge i_hclk);
    i_hreset_n = 1'b1;
    slave_clr(); tick();
    start_req(1'b1, 32'h10, 5'd1); tick(); i_start = 1'b0;
    wait_done("t5_done_seen", 20);
    chk("t5_err", done_err, 1'b0);
    chk("t5_nbeats", aq_addr.size(), 1);
    chk_beat("t5_single", 0, 32'h10, 2'd2, 3'd0);
    chk("t5_wrd", wrd_cnt, 1);

    // i_start held through a burst, then restart after o_done
    slave_clr(); tick();
    start_req(1'b1, 32'h20, 5'd2);
    wait_done("t6_done_seen", 20);
    i_addr = 32'h80; i_len = 5'd1;
    tick();
    chk("t6_no_start_in_done", o_htrans, 2'd0);
    chk("t6_single_req", aq_addr.size(), 2);
    chk("t6_one_done", done_cnt, 1);
    tick();
    i_start = 1'b0;
    chk("t6_restart_trans", o_htrans, 2'd2);
    chk("t6_restart_addr", o_haddr, 32'h80);
    done_cnt = 0;
    wait_done("t6_done2_seen", 20);
    chk("t6_err", done_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
